// File: rtl/load_response_tracker_pkg.sv
// cva5_types: shared types for the load response path.
// Holds the instruction ID type, the load width/sign codes and the
// per-entry attribute record kept by load_response_tracker.
package cva5_types;

  localparam int ID_W = 4;
  typedef logic [ID_W-1:0] id_t;

  // Load width/sign codes carried on fn3
  localparam logic [2:0] FN3_LB  = 3'b000;
  localparam logic [2:0] FN3_LH  = 3'b001;
  localparam logic [2:0] FN3_LW  = 3'b010;
  localparam logic [2:0] FN3_LBU = 3'b100;
  localparam logic [2:0] FN3_LHU = 3'b101;

  typedef struct packed {
    id_t        id;
    logic [2:0] fn3;
    logic [1:0] addr_lo;
    logic [1:0] subunit;
  } load_attributes_t;

endpackage

// File: rtl/load_data_align.sv
// load_data_align: combinational alignment and extension of a raw load word.
// Ports:
//   data    - raw 32-bit word from the memory sub-unit
//   fn3     - load width/sign code
//   addr_lo - byte offset of the load within the word
//   result  - word shifted down to the addressed byte, then sign/zero extended
module load_data_align
  import cva5_types::*;
(
  input  logic [31:0] data,
  input  logic [2:0]  fn3,
  input  logic [1:0]  addr_lo,
  output logic [31:0] result
);

  logic [31:0] shifted_s;

  // Move the addressed byte to bit 0, then extend according to fn3
  always_comb begin
    shifted_s = data >> {addr_lo, 3'b000};
    case (fn3)
      FN3_LB:  result = {{24{shifted_s[7]}}, shifted_s[7:0]};
      FN3_LH:  result = {{16{shifted_s[15]}}, shifted_s[15:0]};
      FN3_LBU: result = {24'h000000, shifted_s[7:0]};
      FN3_LHU: result = {16'h0000, shifted_s[15:0]};
      default: result = shifted_s;
    endcase
  end

endmodule

// File: rtl/load_response_tracker_checker.sv
// load_response_tracker_checker: protocol properties on the tracker inputs.
// Ports:
//   clk, rst    - clock and synchronous active-high reset
//   load_req    - a load is being presented for allocation
//   issue_ready - tracker has a free entry
//   rsp_illegal - a response strobe arrived that the fill entry does not accept
module load_response_tracker_checker (
  input logic clk,
  input logic rst,
  input logic load_req,
  input logic issue_ready,
  input logic rsp_illegal
);

  // Loads must never be issued into a full tracker
  a_no_issue_when_full: assert property (@(posedge clk) disable iff (rst)
    !(load_req && !issue_ready));

  // Responses must come from the fill entry's sub-unit and only when one is outstanding
  a_rsp_in_order: assert property (@(posedge clk) disable iff (rst)
    !rsp_illegal);

endmodule

// File: rtl/load_response_tracker.sv
// load_response_tracker: in-order tracker for in-flight loads.
// Loads are allocated at issue, filled by the owning sub-unit's response in
// issue order, and presented for writeback aligned/extended until acknowledged.
// Ports:
//   clk, rst                         - clock, synchronous active-high reset
//   issue_valid/load/id/fn3/addr_lo/subunit - issued operation and its attributes
//   issue_ready                      - a free entry exists
//   rsp_valid, rsp_data              - per-sub-unit response strobe and raw word
//   wb_valid, wb_id, wb_data, wb_ack - writeback handshake for the oldest load
//   empty                            - no entries allocated
module load_response_tracker
  import cva5_types::*;
#(
  parameter int DEPTH        = 4,
  parameter int NUM_SUBUNITS = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         issue_valid,
  input  logic                         issue_load,
  input  id_t                          issue_id,
  input  logic [2:0]                   issue_fn3,
  input  logic [1:0]                   issue_addr_lo,
  input  logic [1:0]                   issue_subunit,
  output logic                         issue_ready,
  input  logic [NUM_SUBUNITS-1:0]      rsp_valid,
  input  logic [NUM_SUBUNITS-1:0][31:0] rsp_data,
  output logic                         wb_valid,
  output id_t                          wb_id,
  output logic [31:0]                  wb_data,
  input  logic                         wb_ack,
  output logic                         empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  load_attributes_t attr_r [DEPTH];
  logic [31:0]      data_r [DEPTH];
  logic [DEPTH-1:0] done_r;
  logic [PTR_W-1:0] alloc_ptr_r, fill_ptr_r, retire_ptr_r;
  logic [CNT_W-1:0] count_r;    // allocated entries
  logic [CNT_W-1:0] pending_r;  // allocated but not yet filled

  logic                    alloc_s, fill_s, retire_s, load_req_s, rsp_illegal_s;
  logic [NUM_SUBUNITS-1:0] accept_mask_s;
  logic [31:0]             fill_data_s, retire_data_s, aligned_s;
  load_attributes_t        fill_attr_s, retire_attr_s, new_attr_s;

  // Handshake decode: allocation, in-order fill acceptance and retire
  always_comb begin
    load_req_s    = issue_valid && issue_load;
    issue_ready   = (count_r < DEPTH_C);
    empty         = (count_r == '0);
    alloc_s       = load_req_s && issue_ready;
    new_attr_s    = '{id: issue_id, fn3: issue_fn3, addr_lo: issue_addr_lo,
                      subunit: issue_subunit};
    fill_attr_s   = attr_r[fill_ptr_r];
    retire_attr_s = attr_r[retire_ptr_r];
    retire_data_s = data_r[retire_ptr_r];
    accept_mask_s = '0;
    fill_data_s   = 32'h0000_0000;
    // Only the sub-unit owning the oldest unfilled entry may respond
    for (int i = 0; i < NUM_SUBUNITS; i++) begin
      if ((pending_r != '0) && (int'(fill_attr_s.subunit) == i)) begin
        accept_mask_s[i] = 1'b1;
        fill_data_s      = rsp_data[i];
      end else begin
        accept_mask_s[i] = 1'b0;
      end
    end
    fill_s        = |(rsp_valid & accept_mask_s);
    rsp_illegal_s = |(rsp_valid & ~accept_mask_s);
    wb_valid      = done_r[retire_ptr_r];
    retire_s      = wb_valid && wb_ack;
  end

  load_data_align u_align (
    .data    (retire_data_s),
    .fn3     (retire_attr_s.fn3),
    .addr_lo (retire_attr_s.addr_lo),
    .result  (aligned_s)
  );

  // Writeback outputs read as zero whenever no result is being presented
  always_comb begin
    if (wb_valid) begin
      wb_id   = retire_attr_s.id;
      wb_data = aligned_s;
    end else begin
      wb_id   = '0;
      wb_data = 32'h0000_0000;
    end
  end

  // Entry payload storage; contents are qualified by done_r so no reset needed
  always_ff @(posedge clk) begin
    if (!rst && alloc_s) begin
      attr_r[alloc_ptr_r] <= new_attr_s;
    end
    if (!rst && fill_s) begin
      data_r[fill_ptr_r] <= fill_data_s;
    end
  end

  // Pointers, occupancy counters and done flags
  always_ff @(posedge clk) begin
    if (rst) begin
      alloc_ptr_r  <= '0;
      fill_ptr_r   <= '0;
      retire_ptr_r <= '0;
      count_r      <= '0;
      pending_r    <= '0;
      done_r       <= '0;
    end else begin
      // The three indices never coincide: alloc needs a non-full buffer,
      // fill an undone entry, retire a done one
      if (alloc_s) begin
        done_r[alloc_ptr_r] <= 1'b0;
        alloc_ptr_r         <= alloc_ptr_r + PTR_ONE;
      end
      if (fill_s) begin
        done_r[fill_ptr_r] <= 1'b1;
        fill_ptr_r         <= fill_ptr_r + PTR_ONE;
      end
      if (retire_s) begin
        done_r[retire_ptr_r] <= 1'b0;
        retire_ptr_r         <= retire_ptr_r + PTR_ONE;
      end
      case ({alloc_s, retire_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
      case ({alloc_s, fill_s})
        2'b10:   pending_r <= pending_r + CNT_ONE;
        2'b01:   pending_r <= pending_r - CNT_ONE;
        default: pending_r <= pending_r;
      endcase
    end
  end

  load_response_tracker_checker u_checker (
    .clk         (clk),
    .rst         (rst),
    .load_req    (load_req_s),
    .issue_ready (issue_ready),
    .rsp_illegal (rsp_illegal_s)
  );

endmodule

// File: tb/tb_load_response_tracker.sv
// tb_load_response_tracker: table-driven alignment vectors plus hand-written
// multi-cycle sequences; writeback results are checked against a scoreboard
// filled when responses are driven.
module tb_load_response_tracker;
  import cva5_types::*;

  logic            clk = 1'b0;
  logic            rst;
  logic            issue_valid, issue_load;
  id_t             issue_id;
  logic [2:0]      issue_fn3;
  logic [1:0]      issue_addr_lo, issue_subunit;
  logic            issue_ready;
  logic [3:0]      rsp_valid;
  logic [3:0][31:0] rsp_data;
  logic            wb_valid;
  id_t             wb_id;
  logic [31:0]     wb_data;
  logic            wb_ack;
  logic            empty;

  load_response_tracker #(.DEPTH(4), .NUM_SUBUNITS(4)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_load(issue_load), .issue_id(issue_id),
    .issue_fn3(issue_fn3), .issue_addr_lo(issue_addr_lo), .issue_subunit(issue_subunit),
    .issue_ready(issue_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .wb_valid(wb_valid), .wb_id(wb_id), .wb_data(wb_data), .wb_ack(wb_ack),
    .empty(empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    id_t        id;
    logic [2:0] fn3;
    logic [1:0] a;
    logic [1:0] sub;
  } pend_t;

  typedef struct {
    id_t         id;
    logic [31:0] data;
  } sb_t;

  typedef struct {
    logic [2:0]  fn3;
    logic [1:0]  a;
    logic [31:0] raw;
    logic [31:0] exp;
  } vec_t;

  pend_t pend_q[$];
  sb_t   sb_q[$];
  vec_t  vecs[9];
  int    n_cmp  = 0;
  int    n_fail = 0;
  int    next_id = 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference alignment: pick byte/half explicitly by offset
  function automatic logic [31:0] model(input logic [31:0] raw, input logic [2:0] fn3,
                                        input logic [1:0] a);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] w;
    case (a)
      2'd0: begin b = raw[7:0];   h = raw[15:0];         w = raw; end
      2'd1: begin b = raw[15:8];  h = raw[23:8];         w = {8'h00, raw[31:8]}; end
      2'd2: begin b = raw[23:16]; h = raw[31:16];        w = {16'h0000, raw[31:16]}; end
      default: begin b = raw[31:24]; h = {8'h00, raw[31:24]}; w = {24'h000000, raw[31:24]}; end
    endcase
    case (fn3)
      3'b000:  return b[7] ? {24'hFFFFFF, b} : {24'h000000, b};
      3'b001:  return h[15] ? {16'hFFFF, h} : {16'h0000, h};
      3'b100:  return {24'h000000, b};
      3'b101:  return {16'h0000, h};
      default: return w;
    endcase
  endfunction

  // One clock: compare any handshaken writeback, advance, drop one-shot inputs
  task automatic cyc();
    sb_t e;
    #2;
    if (!rst && wb_valid && wb_ack) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_wb", 32'(wb_id), 32'hFFFF_FFFF);
      end else begin
        e = sb_q.pop_front();
        check("sb_wb_id", 32'(wb_id), 32'(e.id));
        check("sb_wb_data", wb_data, e.data);
      end
    end
    @(posedge clk);
    #1;
    issue_valid = 1'b0;
    rsp_valid   = '0;
    rsp_data    = {$urandom(), $urandom(), $urandom(), $urandom()};
  endtask

  task automatic set_issue(input logic [2:0] fn3, input logic [1:0] a, input logic [1:0] sub);
    pend_t p;
    p.id = id_t'(next_id);
    p.fn3 = fn3;
    p.a = a;
    p.sub = sub;
    next_id++;
    pend_q.push_back(p);
    issue_valid   = 1'b1;
    issue_load    = 1'b1;
    issue_id      = p.id;
    issue_fn3     = fn3;
    issue_addr_lo = a;
    issue_subunit = sub;
  endtask

  task automatic set_rsp_exp(input logic [31:0] raw, input logic [31:0] exp);
    pend_t p;
    sb_t   e;
    if (pend_q.size() != 0) begin
      p = pend_q.pop_front();
      rsp_valid[p.sub] = 1'b1;
      rsp_data[p.sub]  = raw;
      e.id   = p.id;
      e.data = exp;
      sb_q.push_back(e);
    end
  endtask

  task automatic set_rsp(input logic [31:0] raw);
    if (pend_q.size() != 0) begin
      set_rsp_exp(raw, model(raw, pend_q[0].fn3, pend_q[0].a));
    end
  endtask

  task automatic drain();
    wb_ack = 1'b1;
    for (int k = 0; k < 30 && !(empty && sb_q.size() == 0); k++) begin
      if (pend_q.size() != 0) set_rsp($urandom());
      cyc();
    end
    check("drain_empty", 32'(empty), 32'd1);
    check("drain_sb_left", sb_q.size(), 32'd0);
    wb_ack = 1'b0;
  endtask

  initial begin
    vecs[0] = '{3'b000, 2'd3, 32'h80FF_FF12, 32'hFFFF_FF80};
    vecs[1] = '{3'b101, 2'd2, 32'hBEEF_0000, 32'h0000_BEEF};
    vecs[2] = '{3'b001, 2'd2, 32'hBEEF_0000, 32'hFFFF_BEEF};
    vecs[3] = '{3'b100, 2'd1, 32'h1234_5678, 32'h0000_0056};
    vecs[4] = '{3'b000, 2'd0, 32'h0000_007F, 32'h0000_007F};
    vecs[5] = '{3'b001, 2'd0, 32'h0000_8001, 32'hFFFF_8001};
    vecs[6] = '{3'b010, 2'd0, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vecs[7] = '{3'b101, 2'd0, 32'h1234_F00D, 32'h0000_F00D};
    vecs[8] = '{3'b110, 2'd0, 32'hCAFE_BABE, 32'hCAFE_BABE};

    rst = 1'b1; issue_valid = 1'b0; issue_load = 1'b0; issue_id = '0;
    issue_fn3 = 3'b000; issue_addr_lo = 2'b00; issue_subunit = 2'b00;
    rsp_valid = '0; rsp_data = '0; wb_ack = 1'b0;
    cyc(); cyc();

    // Reset values
    check("rst_issue_ready", 32'(issue_ready), 32'd1);
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_wb_id", 32'(wb_id), 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    rst = 1'b0;
    cyc();

    // A store allocates nothing
    issue_valid = 1'b1; issue_load = 1'b0;
    cyc();
    check("store_empty", 32'(empty), 32'd1);

    // Alignment/extension table, one load at a time
    for (int i = 0; i < 9; i++) begin
      set_issue(vecs[i].fn3, vecs[i].a, 2'(i));
      cyc();
      check("vec_wb_valid_early", 32'(wb_valid), 32'd0);
      check("vec_not_empty", 32'(empty), 32'd0);
      set_rsp_exp(vecs[i].raw, vecs[i].exp);
      cyc();
      check("vec_wb_valid", 32'(wb_valid), 32'd1);
      check("vec_wb_data", wb_data, vecs[i].exp);
      wb_ack = 1'b1;
      cyc();
      wb_ack = 1'b0;
      check("vec_empty_after", 32'(empty), 32'd1);
    end

    // Fill to capacity, then one response + ack frees an entry
    next_id = 1;
    for (int i = 0; i < 4; i++) begin
      set_issue(3'b010, 2'd0, 2'd0);
      cyc();
    end
    check("full_issue_ready", 32'(issue_ready), 32'd0);
    set_rsp($urandom());
    cyc();
    check("full_wb_id", 32'(wb_id), 32'd1);
    check("full_still_not_ready", 32'(issue_ready), 32'd0);
    wb_ack = 1'b1;
    cyc();
    check("after_ack_issue_ready", 32'(issue_ready), 32'd1);
    drain();

    // Out-of-order sub-units with delayed responses, writeback stalled
    next_id = 5;
    set_issue(3'b010, 2'd0, 2'd0); cyc();
    set_issue(3'b010, 2'd0, 2'd2); cyc();
    set_issue(3'b010, 2'd0, 2'd1); cyc();
    cyc(); cyc();
    set_rsp(32'h0000_0A05);
    cyc();
    for (int k = 0; k < 3; k++) begin
      if (k == 0) set_rsp(32'h0000_0B06);
      if (k == 2) set_rsp(32'h0000_0C07);
      cyc();
      check("hold_wb_valid", 32'(wb_valid), 32'd1);
      check("hold_wb_id", 32'(wb_id), 32'd5);
      check("hold_wb_data", wb_data, 32'h0000_0A05);
    end
    drain();

    // Steady state alloc + fill + retire every cycle, across pointer wrap
    set_issue(3'b100, 2'd1, 2'd3); cyc();
    set_issue(3'b001, 2'd2, 2'd1); set_rsp($urandom()); cyc();
    wb_ack = 1'b1;
    for (int k = 0; k < 20; k++) begin
      set_issue(3'(k % 6), 2'(k), 2'(k + 1));
      set_rsp($urandom());
      cyc();
      check("steady_empty", 32'(empty), 32'd0);
      check("steady_ready", 32'(issue_ready), 32'd1);
      check("steady_wb_valid", 32'(wb_valid), 32'd1);
    end
    drain();

    // Reset with entries outstanding; a response in the reset cycle is dropped
    for (int i = 0; i < 3; i++) begin
      set_issue(3'b010, 2'd0, 2'(i)); cyc();
    end
    set_rsp($urandom()); cyc();
    check("pre_rst_wb_valid", 32'(wb_valid), 32'd1);
    rst = 1'b1;
    set_rsp($urandom());
    cyc();
    rst = 1'b0;
    pend_q.delete();
    sb_q.delete();
    check("mid_rst_empty", 32'(empty), 32'd1);
    check("mid_rst_wb_valid", 32'(wb_valid), 32'd0);
    check("mid_rst_issue_ready", 32'(issue_ready), 32'd1);
    check("mid_rst_wb_data", wb_data, 32'd0);
    cyc();
    check("post_rst_wb_valid", 32'(wb_valid), 32'd0);
    check("post_rst_empty", 32'(empty), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
